// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types for the FP divider issue front end.
package fpu_pkg;
    localparam int FDIV_TAG_W = 6;
    localparam logic [31:0] FP_ZERO = 32'h0;
    typedef struct packed {
        logic [31:0]           x1;
        logic [31:0]           x2;
        logic [FDIV_TAG_W-1:0] tag;
    } fdiv_req_t;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} fdiv_iss_state_t;
    function automatic logic is_fp_zero(input logic [31:0] x);
        return x[30:0] == 31'd0;
    endfunction
endpackage

// File: rtl/fdiv_req_fifo.sv
// fdiv_req_fifo: synchronous request FIFO; full blocks pushes even when a pop coincides.
module fdiv_req_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  fdiv_req_t din,
    output fdiv_req_t dout,
    output logic      full,
    output logic      empty
);
    localparam int AW = $clog2(DEPTH);
    fdiv_req_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/fdiv_issue_ctrl.sv
// fdiv_issue_ctrl: queues tagged divides, issues them one at a time to fdiv_p, holds results for writeback.
// Define FDIV_ZERO_FASTPATH_EN to answer zero-operand divides directly without touching the divider.
module fdiv_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = FDIV_TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_x1,
    input  logic [31:0]      req_x2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             div_en,
    output logic [31:0]      div_x1,
    output logic [31:0]      div_x2,
    input  logic [31:0]      div_y,
    input  logic             div_valid,
    input  logic             div_idle,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [31:0]      wb_data,
    output logic [TAG_W-1:0] wb_tag,
    output logic             busy
);
    fdiv_iss_state_t state, state_n;
    fdiv_req_t req, head;
    logic full, empty, pop, issue, fast, capture;
    logic [TAG_W-1:0] tag_q;
    assign req = '{x1: req_x1, x2: req_x2, tag: FDIV_TAG_W'(req_tag)};
    assign req_ready = !full;
    assign pop = issue || fast;
    assign busy = !empty || state != S_IDLE || wb_valid;
    fdiv_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req_valid && req_ready),
        .pop   (pop),
        .din   (req),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
    // Issue waits on an empty writeback slot so the non-stallable valid pulse always lands.
    always_comb begin
        state_n = state;
        div_en = 1'b0;
        issue = 1'b0;
        fast = 1'b0;
        capture = 1'b0;
        case (state)
            S_IDLE: if (!empty && !wb_valid) begin
`ifdef FDIV_ZERO_FASTPATH_EN
                if (is_fp_zero(head.x1) || is_fp_zero(head.x2)) fast = 1'b1;
                else
`endif
                if (div_idle) begin
                    issue = 1'b1;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                div_en = 1'b1;
                state_n = S_WAIT;
            end
            S_WAIT: if (div_valid) begin
                capture = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            div_x1   <= '0;
            div_x2   <= '0;
            tag_q    <= '0;
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_tag   <= '0;
        end else begin
            state <= state_n;
            if (issue) begin
                div_x1 <= head.x1;
                div_x2 <= head.x2;
                tag_q  <= TAG_W'(head.tag);
            end
            if (capture || fast) begin
                wb_valid <= 1'b1;
                wb_data  <= capture ? div_y : FP_ZERO;
                wb_tag   <= capture ? tag_q : TAG_W'(head.tag);
            end else if (wb_valid && wb_ready) begin
                wb_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fdiv_issue_ctrl.sv
// tb_fdiv_issue_ctrl: directed checks of fdiv_issue_ctrl against a 4-cycle fdiv_p stand-in.
// Build with FDIV_ZERO_FASTPATH_EN to check the zero fast path instead of the divider path.
module tb_fdiv_issue_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req_valid = 1'b0, req_ready;
    logic [31:0] req_x1 = '0, req_x2 = '0;
    logic [5:0] req_tag = '0;
    logic div_en, div_valid, div_idle;
    logic [31:0] div_x1, div_x2;
    logic [31:0] div_y = '0;
    logic wb_valid, wb_ready = 1'b1, busy;
    logic [31:0] wb_data;
    logic [5:0] wb_tag;
    logic [3:0] sh = '0;
    logic stall = 1'b0;
    int en_cnt = 0;
    int vecs = 0, errs = 0;

    fdiv_issue_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x1(req_x1), .req_x2(req_x2), .req_tag(req_tag),
        .div_en(div_en), .div_x1(div_x1), .div_x2(div_x2),
        .div_y(div_y), .div_valid(div_valid), .div_idle(div_idle),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_tag(wb_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    // Known quotients for the operand pairs used below; fdiv_p has no reset.
    function automatic logic [31:0] fref(input logic [31:0] a, input logic [31:0] b);
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return 32'h0000_0000;
        if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (a == 32'h3F80_0000 && b == 32'h4080_0000) return 32'h3E80_0000;
        return 32'hDEAD_BEEF;
    endfunction

    always @(posedge clk) begin
        sh <= {sh[2:0], div_en};
        if (div_en) begin
            div_y <= fref(div_x1, div_x2);
            en_cnt <= en_cnt + 1;
        end
    end
    assign div_valid = sh[3];
    assign div_idle = ~|sh && !stall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [5:0] t);
        req_valid = 1'b1;
        req_x1 = a;
        req_x2 = b;
        req_tag = t;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic lat(output int n);
        n = 1;
        while (!wb_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("wb_timeout", {31'd0, wb_valid}, 32'd1);
    endtask

    int n, e0;
    logic [31:0] d;
    logic [5:0] t;
    logic ok, seen;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_div_en", {31'd0, div_en}, 32'd0);
        chk("rst_div_x1", div_x1, 32'd0);
        chk("rst_div_x2", div_x2, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_tag", {26'd0, wb_tag}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Single op through the divider.
        e0 = en_cnt;
        push(32'h40C0_0000, 32'h4000_0000, 6'd5);
        lat(n);
        chk("single_lat", n, 32'd7);
        chk("single_data", wb_data, 32'h4040_0000);
        chk("single_tag", {26'd0, wb_tag}, 32'd5);
        chk("single_en_cnt", en_cnt - e0, 32'd1);
        @(negedge clk);
        chk("single_wb_clr", {31'd0, wb_valid}, 32'd0);
        chk("single_idle", {31'd0, busy}, 32'd0);

        // Fill the FIFO while the divider reports busy, then refuse a push against a concurrent pop.
        stall = 1'b1;
        for (int i = 1; i <= 4; i++) push(32'h3F80_0000, 32'h4080_0000, 6'(i));
        chk("full_req_ready", {31'd0, req_ready}, 32'd0);
        chk("full_busy", {31'd0, busy}, 32'd1);
        stall = 1'b0;
        push(32'h40C0_0000, 32'h4000_0000, 6'd9);
        chk("after_pop_ready", {31'd0, req_ready}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            lat(n);
            chk("order_data", wb_data, 32'h3E80_0000);
            chk("order_tag", {26'd0, wb_tag}, i);
            @(negedge clk);
        end
        seen = 1'b0;
        repeat (20) begin
            if (wb_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("no_extra_result", {31'd0, seen}, 32'd0);
        chk("drain_busy", {31'd0, busy}, 32'd0);

        // Writeback back-pressure holds the result and blocks issue.
        wb_ready = 1'b0;
        push(32'h40C0_0000, 32'h4000_0000, 6'd5);
        push(32'h3F80_0000, 32'h4080_0000, 6'd7);
        lat(n);
        d = wb_data;
        t = wb_tag;
        e0 = en_cnt;
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!wb_valid || wb_data !== d || wb_tag !== t) ok = 1'b0;
        end
        chk("hold_stable", {31'd0, ok}, 32'd1);
        chk("hold_no_issue", en_cnt - e0, 32'd0);
        chk("hold_data", wb_data, 32'h4040_0000);
        chk("hold_tag", {26'd0, wb_tag}, 32'd5);
        wb_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!div_en && n < 20);
        chk("resume_en_at", n, 32'd2);
        lat(n);
        chk("resume_data", wb_data, 32'h3E80_0000);
        chk("resume_tag", {26'd0, wb_tag}, 32'd7);
        @(negedge clk);

        // Reset while waiting on the divider; its later valid pulse must be ignored.
        push(32'h40C0_0000, 32'h4000_0000, 6'd11);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            if (wb_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("rst_mid_wb", {31'd0, seen}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mid_div_x1", div_x1, 32'd0);

        // Zero divisor.
        e0 = en_cnt;
        push(32'h3F80_0000, 32'h0000_0000, 6'd3);
        lat(n);
        chk("zero_data", wb_data, 32'h0000_0000);
        chk("zero_tag", {26'd0, wb_tag}, 32'd3);
`ifdef FDIV_ZERO_FASTPATH_EN
        chk("zero_lat", n, 32'd2);
        chk("zero_en_cnt", en_cnt - e0, 32'd0);
`else
        chk("zero_lat", n, 32'd7);
        chk("zero_en_cnt", en_cnt - e0, 32'd1);
`endif
        @(negedge clk);
        chk("zero_wb_clr", {31'd0, wb_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
